pipe_stage_skid: RTL and testbench

- Parametrised successor to the fixed-field D→EX flop bank: a generic elastic pipeline stage carrying an opaque DATA_W payload with valid/ready handshake.
- Sits between any two pipeline stages (D→EX first, then EX→MEM and MEM→WB), so stall is back-pressure rather than a bubble-inserting clear.
- Optional 2-entry skid buffer keeps in_ready registered.
- Separate flush squashes in-flight entries.
- Saturating stall and drop counters for performance analysis.

---
 rtl/pipe_stage_skid.sv | 136 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Elastic valid/ready pipeline stage with optional 2-entry skid buffer, flush,
// and saturating stall/drop performance counters.
module pipe_stage_skid #(
    parameter int DATA_W = 64,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   main_data_reg, main_data_next;
    logic [DATA_W-1:0]   skid_data_reg, skid_data_next;
    logic [CNT_W-1:0]    stall_cnt_reg, stall_cnt_next;
    logic [CNT_W-1:0]    drop_cnt_reg, drop_cnt_next;
    logic [1:0]          drop_inc;
    logic [CNT_W+1:0]    drop_sum;
    logic                main_valid, skid_valid;
    logic                in_xfer, out_xfer;

    assign main_valid = (state_reg != EMPTY);
    assign skid_valid = (state_reg == FULL);
    assign in_xfer    = in_valid & in_ready;
    assign out_xfer   = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= EMPTY;
            main_data_reg <= '0;
            skid_data_reg <= '0;
            stall_cnt_reg <= '0;
            drop_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            main_data_reg <= main_data_next;
            skid_data_reg <= skid_data_next;
            stall_cnt_reg <= stall_cnt_next;
            drop_cnt_reg  <= drop_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        main_data_next = main_data_reg;
        skid_data_next = skid_data_reg;
        if (flush) begin
            // Bubbles after a flush carry a zero payload.
            state_next     = EMPTY;
            main_data_next = '0;
            skid_data_next = '0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (in_valid) begin
                        main_data_next = in_data;
                        state_next     = BUSY;
                    end
                end
                BUSY: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            main_data_next = in_data;
                        end else begin
                            main_data_next = '0;
                            state_next     = EMPTY;
                        end
                    end else if (SKID != 0 && in_xfer) begin
                        skid_data_next = in_data;
                        state_next     = FULL;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        main_data_next = skid_data_reg;
                        skid_data_next = '0;
                        state_next     = BUSY;
                    end
                end
                default: begin
                    state_next     = EMPTY;
                    main_data_next = '0;
                    skid_data_next = '0;
                end
            endcase
        end
    end

    always_comb begin
        out_valid = main_valid;
        out_data  = main_data_reg;
        stall_cnt = stall_cnt_reg;
        drop_cnt  = drop_cnt_reg;
        // With the skid buffer, in_ready depends on registered state only.
        if (SKID != 0) begin
            in_ready = (state_reg != FULL);
        end else begin
            in_ready = ~main_valid | out_ready;
        end
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (out_valid && !out_ready && stall_cnt_reg != CNT_MAX) begin
            stall_cnt_next = stall_cnt_reg + CNT_ONE;
        end
        drop_inc      = '0;
        drop_sum      = '0;
        drop_cnt_next = drop_cnt_reg;
        if (flush) begin
            // A main entry leaving downstream this cycle is delivered, not dropped.
            drop_inc      = {1'b0, main_valid & ~out_xfer} + {1'b0, skid_valid} + {1'b0, in_xfer};
            drop_sum      = {2'b00, drop_cnt_reg} + {{CNT_W{1'b0}}, drop_inc};
            drop_cnt_next = (drop_sum > {2'b00, CNT_MAX}) ? CNT_MAX : drop_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: vector tables plus an in-order scoreboard, run on a
// SKID=1 instance and a SKID=0 / CNT_W=4 instance sharing the same stimulus.
module tb_pipe_stage_skid;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       flush;
    logic       out_ready;

    logic        a_in_ready, a_out_valid;
    logic [7:0]  a_out_data;
    logic [15:0] a_stall, a_drop;
    logic        b_in_ready, b_out_valid;
    logic [7:0]  b_out_data;
    logic [3:0]  b_stall, b_drop;

    pipe_stage_skid #(.DATA_W(8), .SKID(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .flush(flush), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_data(a_out_data),
        .stall_cnt(a_stall), .drop_cnt(a_drop)
    );

    pipe_stage_skid #(.DATA_W(8), .SKID(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .flush(flush), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_data(b_out_data),
        .stall_cnt(b_stall), .drop_cnt(b_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          sel;
    logic        s_ir, s_ov;
    logic [7:0]  s_od;
    logic [15:0] s_stall, s_drop;

    always_comb begin
        if (sel == 0) begin
            s_ir = a_in_ready; s_ov = a_out_valid; s_od = a_out_data;
            s_stall = a_stall; s_drop = a_drop;
        end else begin
            s_ir = b_in_ready; s_ov = b_out_valid; s_od = b_out_data;
            s_stall = {12'd0, b_stall}; s_drop = {12'd0, b_drop};
        end
    end

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       fl;
        logic       eov;
        logic [7:0] eod;
        logic       eir;
        int         est;
        int         edr;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] sbq[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    function automatic vec_t v(input logic iv, input logic [7:0] id, input logic ordy,
                               input logic fl, input logic eov, input logic [7:0] eod,
                               input logic eir, input int est, input int edr);
        vec_t r;
        r.iv = iv; r.id = id; r.ordy = ordy; r.fl = fl;
        r.eov = eov; r.eod = eod; r.eir = eir; r.est = est; r.edr = edr;
        return r;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] id, input logic ordy,
                         input logic fl);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Called at the negedge: score the handshake, then advance to posedge+1.
    task automatic sb_edge();
        logic       ix, ox;
        logic [7:0] exp_d;
        ix = in_valid & s_ir;
        ox = s_ov & out_ready;
        if (ox) begin
            if (sbq.size() == 0) begin
                n_checks++;
                $display("FAIL sb_underflow: got out_data %0h expected no output", s_od);
            end else begin
                exp_d = sbq.pop_front();
                check("sb_data", -1, {24'd0, s_od}, {24'd0, exp_d});
            end
        end
        if (flush) sbq.delete();
        else if (ix) sbq.push_back(in_data);
        $display("txn dut=%0d iv=%0b id=%0h ir=%0b ov=%0b od=%0h ordy=%0b fl=%0b",
                 sel, in_valid, in_data, s_ir, s_ov, s_od, out_ready, flush);
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string pfx);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].fl);
            @(negedge clk);
            check({pfx, " out_valid"}, i, {31'd0, s_ov}, {31'd0, tbl[i].eov});
            check({pfx, " out_data"},  i, {24'd0, s_od}, {24'd0, tbl[i].eod});
            check({pfx, " in_ready"},  i, {31'd0, s_ir}, {31'd0, tbl[i].eir});
            check({pfx, " stall_cnt"}, i, {16'd0, s_stall}, tbl[i].est);
            check({pfx, " drop_cnt"},  i, {16'd0, s_drop}, tbl[i].edr);
            sb_edge();
        end
    endtask

    task automatic apply_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbq.delete();
    endtask

    initial begin
        sel = 0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // SKID=1: streaming, back-pressure, flush in FULL/BUSY/EMPTY, FULL drain.
        //            iv  id     rdy fl  ov  od     ir  st dr
        tbl.push_back(v(1, 8'h11, 1, 0, 0, 8'h00, 1, 0, 0));
        tbl.push_back(v(1, 8'h22, 1, 0, 1, 8'h11, 1, 0, 0));
        tbl.push_back(v(1, 8'h33, 1, 0, 1, 8'h22, 1, 0, 0));
        tbl.push_back(v(0, 8'h00, 1, 0, 1, 8'h33, 1, 0, 0));
        tbl.push_back(v(0, 8'h00, 1, 0, 0, 8'h00, 1, 0, 0));
        tbl.push_back(v(1, 8'hA1, 0, 0, 0, 8'h00, 1, 0, 0));
        tbl.push_back(v(1, 8'hA2, 0, 0, 1, 8'hA1, 1, 0, 0));
        tbl.push_back(v(0, 8'h00, 0, 0, 1, 8'hA1, 0, 1, 0));
        tbl.push_back(v(0, 8'h00, 0, 0, 1, 8'hA1, 0, 2, 0));
        tbl.push_back(v(0, 8'h00, 1, 0, 1, 8'hA1, 0, 3, 0));
        tbl.push_back(v(0, 8'h00, 1, 0, 1, 8'hA2, 1, 3, 0));
        tbl.push_back(v(0, 8'h00, 1, 0, 0, 8'h00, 1, 3, 0));
        tbl.push_back(v(1, 8'hB1, 0, 0, 0, 8'h00, 1, 3, 0));
        tbl.push_back(v(1, 8'hB2, 0, 0, 1, 8'hB1, 1, 3, 0));
        tbl.push_back(v(1, 8'hB3, 0, 1, 1, 8'hB1, 0, 4, 0));
        tbl.push_back(v(0, 8'h00, 1, 0, 0, 8'h00, 1, 5, 2));
        tbl.push_back(v(1, 8'hC1, 1, 0, 0, 8'h00, 1, 5, 2));
        tbl.push_back(v(1, 8'hC2, 1, 1, 1, 8'hC1, 1, 5, 2));
        tbl.push_back(v(0, 8'h00, 1, 0, 0, 8'h00, 1, 5, 3));
        tbl.push_back(v(1, 8'hD1, 0, 0, 0, 8'h00, 1, 5, 3));
        tbl.push_back(v(0, 8'h00, 0, 1, 1, 8'hD1, 1, 5, 3));
        tbl.push_back(v(1, 8'hE1, 1, 1, 0, 8'h00, 1, 6, 4));
        tbl.push_back(v(0, 8'h00, 1, 0, 0, 8'h00, 1, 6, 5));
        tbl.push_back(v(1, 8'hF1, 0, 0, 0, 8'h00, 1, 6, 5));
        tbl.push_back(v(1, 8'hF2, 0, 0, 1, 8'hF1, 1, 6, 5));
        tbl.push_back(v(1, 8'hF3, 1, 0, 1, 8'hF1, 0, 7, 5));
        tbl.push_back(v(1, 8'hF3, 1, 0, 1, 8'hF2, 1, 7, 5));
        tbl.push_back(v(0, 8'h00, 1, 0, 1, 8'hF3, 1, 7, 5));
        tbl.push_back(v(0, 8'h00, 1, 0, 0, 8'h00, 1, 7, 5));
        run_table("A");
        check("A sb_empty", 0, sbq.size(), 0);

        // Asynchronous reset in the middle of a cycle while FULL.
        apply_reset();
        drive(1'b1, 8'h5A, 1'b0, 1'b0);
        @(negedge clk); sb_edge();
        drive(1'b1, 8'h5B, 1'b0, 1'b0);
        @(negedge clk); sb_edge();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("rst pre in_ready", 0, {31'd0, a_in_ready}, 0);
        check("rst pre out_data", 0, {24'd0, a_out_data}, 32'h5A);
        check("rst pre stall_cnt", 0, {16'd0, a_stall}, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst async out_valid", 0, {31'd0, a_out_valid}, 0);
        check("rst async out_data",  0, {24'd0, a_out_data}, 0);
        check("rst async in_ready",  0, {31'd0, a_in_ready}, 1);
        check("rst async stall_cnt", 0, {16'd0, a_stall}, 0);
        check("rst async drop_cnt",  0, {16'd0, a_drop}, 0);
        #1;
        rst = 1'b0;
        sbq.delete();
        @(posedge clk);
        #1;
        drive(1'b1, 8'h05, 1'b1, 1'b0);
        @(negedge clk);
        check("post rst out_valid", 0, {31'd0, a_out_valid}, 0);
        sb_edge();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        check("post rst out_valid", 1, {31'd0, a_out_valid}, 1);
        check("post rst out_data",  1, {24'd0, a_out_data}, 32'h05);
        sb_edge();

        // SKID=0, CNT_W=4: combinational in_ready, flush cases, saturation.
        apply_reset();
        sel = 1;
        tbl.delete();
        tbl.push_back(v(1, 8'h11, 1, 0, 0, 8'h00, 1, 0, 0));
        tbl.push_back(v(1, 8'h22, 0, 0, 1, 8'h11, 0, 0, 0));
        tbl.push_back(v(1, 8'h22, 1, 0, 1, 8'h11, 1, 1, 0));
        tbl.push_back(v(0, 8'h00, 1, 0, 1, 8'h22, 1, 1, 0));
        tbl.push_back(v(0, 8'h00, 0, 0, 0, 8'h00, 1, 1, 0));
        tbl.push_back(v(1, 8'h33, 0, 1, 0, 8'h00, 1, 1, 0));
        tbl.push_back(v(1, 8'h44, 0, 0, 0, 8'h00, 1, 1, 1));
        tbl.push_back(v(1, 8'h55, 0, 1, 1, 8'h44, 0, 1, 1));
        tbl.push_back(v(1, 8'h66, 1, 0, 0, 8'h00, 1, 2, 2));
        tbl.push_back(v(1, 8'h77, 1, 1, 1, 8'h66, 1, 2, 2));
        tbl.push_back(v(0, 8'h00, 1, 0, 0, 8'h00, 1, 2, 3));
        tbl.push_back(v(1, 8'h88, 0, 0, 0, 8'h00, 1, 2, 3));
        run_table("B");

        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0);
            @(negedge clk);
            check("B hold out_data", i, {24'd0, b_out_data}, 32'h88);
            check("B hold out_valid", i, {31'd0, b_out_valid}, 1);
            sb_edge();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        check("B stall_sat", 0, {16'd0, s_stall}, 15);
        sb_edge();

        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 1'b1, 1'b1);
            @(negedge clk);
            sb_edge();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        check("B drop_sat", 0, {16'd0, s_drop}, 15);
        check("B stall_keep", 0, {16'd0, s_stall}, 15);
        check("B idle out_valid", 0, {31'd0, s_ov}, 0);
        sb_edge();
        check("B sb_empty", 0, sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
